// File: rtl/mult_div_unit.sv
// Iterative 32-step multiply (radix-2 shift-add) / restoring divide feeding the hi/lo write port.
// Latency: start sampled in cycle T, result and one-cycle hi/lo write strobe in cycle T+33, idle at T+34.
// No backpressure: start is ignored while busy; flush aborts without a write. Divider gated by MDU_DIV_EN.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_out_o,
    output logic [WIDTH-1:0] lo_out_o,
    output logic             hi_write_o,
    output logic             lo_write_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_quo_q, neg_quo_d;     // negate product (MULT) or quotient (DIV)
    logic [WIDTH-1:0] mcand_q, mcand_d;         // multiplicand or divisor magnitude
    logic [WIDTH-1:0] hi_acc_q, hi_acc_d;       // upper product half / remainder
    logic [WIDTH-1:0] lo_acc_q, lo_acc_d;       // multiplier bits / dividend-then-quotient
    logic [WIDTH-1:0] hi_out_q, hi_out_d;
    logic [WIDTH-1:0] lo_out_q, lo_out_d;
`ifdef MDU_DIV_EN
    logic             neg_rem_q, neg_rem_d;
    logic             div0_q, div0_d;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
`endif

    logic               signed_op;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0]   fix_hi, fix_lo;
    logic               res_wr;
    logic               strobe;

    // Operand magnitudes at launch and one shift-add / restoring-divide step on the accumulator.
    always_comb begin
        signed_op = ~op_i[0];
        a_mag     = (signed_op && a_i[WIDTH-1]) ? -a_i : a_i;
        b_mag     = (signed_op && b_i[WIDTH-1]) ? -b_i : b_i;
        mul_sum   = {1'b0, hi_acc_q} + (lo_acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        step_hi   = mul_sum[WIDTH:1];
        step_lo   = {mul_sum[0], lo_acc_q[WIDTH-1:1]};
`ifdef MDU_DIV_EN
        div_shift = {hi_acc_q, lo_acc_q[WIDTH-1]};
        // Only used when the trial subtract succeeds, so the result always fits in WIDTH bits.
        div_diff  = div_shift[WIDTH-1:0] - mcand_q;
        if (is_div_q) begin
            if (div_shift >= {1'b0, mcand_q}) begin
                step_hi = div_diff;
                step_lo = {lo_acc_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {lo_acc_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    // Sign fix-up of the final step's result; divide-by-zero quotient forced to all ones.
    always_comb begin
        prod_raw = {step_hi, step_lo};
        prod_fix = neg_quo_q ? -prod_raw : prod_raw;
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
`ifdef MDU_DIV_EN
        if (is_div_q) begin
            fix_lo = div0_q ? {WIDTH{1'b1}} : (neg_quo_q ? -step_lo : step_lo);
            fix_hi = neg_rem_q ? -step_hi : step_hi;
        end
`endif
    end

`ifdef MDU_DIV_EN
    assign res_wr = 1'b1;
`else
    // Without a divider, DIV/DIVU run the full sequence but never touch hi/lo.
    assign res_wr = ~is_div_q;
`endif

    // Next-state: launch capture in IDLE, 32 steps in CALC, result loaded on entry to DONE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_quo_d = neg_quo_q;
        mcand_d   = mcand_q;
        hi_acc_d  = hi_acc_q;
        lo_acc_d  = lo_acc_q;
        hi_out_d  = hi_out_q;
        lo_out_d  = lo_out_q;
`ifdef MDU_DIV_EN
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i && !flush_i) begin
                    state_d   = S_CALC;
                    cnt_d     = CW'(WIDTH - 1);
                    is_div_d  = op_i[1];
                    neg_quo_d = signed_op & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                    hi_acc_d  = '0;
                    if (op_i[1]) begin
                        mcand_d  = b_mag;
                        lo_acc_d = a_mag;
                    end else begin
                        mcand_d  = a_mag;
                        lo_acc_d = b_mag;
                    end
`ifdef MDU_DIV_EN
                    neg_rem_d = signed_op & a_i[WIDTH-1];
                    div0_d    = (b_i == '0);
`endif
                end
            end
            S_CALC: begin
                hi_acc_d = step_hi;
                lo_acc_d = step_lo;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    if (res_wr) begin
                        hi_out_d = fix_hi;
                        lo_out_d = fix_lo;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort: drop the operation and leave hi/lo untouched.
        if (flush_i && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            hi_out_d = hi_out_q;
            lo_out_d = lo_out_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            mcand_q   <= '0;
            hi_acc_q  <= '0;
            lo_acc_q  <= '0;
            hi_out_q  <= '0;
            lo_out_q  <= '0;
`ifdef MDU_DIV_EN
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_quo_q <= neg_quo_d;
            mcand_q   <= mcand_d;
            hi_acc_q  <= hi_acc_d;
            lo_acc_q  <= lo_acc_d;
            hi_out_q  <= hi_out_d;
            lo_out_q  <= lo_out_d;
`ifdef MDU_DIV_EN
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
`endif
        end
    end

    // Strobes are suppressed in the same cycle that flush or reset is raised.
    assign strobe     = (state_q == S_DONE) && !flush_i && !rst_i;
    assign done_o     = strobe;
    assign hi_write_o = strobe && res_wr;
    assign lo_write_o = strobe && res_wr;
    assign busy_o     = (state_q != S_IDLE);
    assign hi_out_o   = hi_out_q;
    assign lo_out_o   = lo_out_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: signed/unsigned multiply and divide, divide-by-zero, overflow,
// ignored restart, flush in each state, reset mid-operation. Expectations are hand-computed constants.
module tb_mult_div_unit;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;
`ifdef MDU_DIV_EN
    localparam logic DIV_ON = 1'b1;
`else
    localparam logic DIV_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done, hi_write, lo_write;
    logic [31:0] hi_out, lo_out;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .op_i       (op),
        .a_i        (a),
        .b_i        (b),
        .flush_i    (flush),
        .busy_o     (busy),
        .done_o     (done),
        .hi_out_o   (hi_out),
        .lo_out_o   (lo_out),
        .hi_write_o (hi_write),
        .lo_write_o (lo_write)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // One full operation: start in cycle T, result checked at T+33, idle at T+34.
    task automatic run_op(input string tag, input logic [1:0] opv, input logic [31:0] av,
                          input logic [31:0] bv, input logic wr,
                          input logic [31:0] eh, input logic [31:0] el);
        logic [31:0] xh, xl;
        int          early;
        xh    = wr ? eh : exp_hi;
        xl    = wr ? el : exp_lo;
        start = 1'b1; op = opv; a = av; b = bv;
        tick();
        start = 1'b0;
        a = ~av; b = ~bv;
        chk1({tag, ".busy_T1"}, busy, 1'b1);
        early = 0;
        for (int c = 1; c < 33; c++) begin
            if (done || hi_write || lo_write || !busy) early++;
            tick();
        end
        chk({tag, ".calc_window"}, 32'(early), 32'd0);
        chk1({tag, ".done"}, done, 1'b1);
        chk1({tag, ".hi_write"}, hi_write, wr);
        chk1({tag, ".lo_write"}, lo_write, wr);
        chk({tag, ".hi"}, hi_out, xh);
        chk({tag, ".lo"}, lo_out, xl);
        exp_hi = xh;
        exp_lo = xl;
        tick();
        chk1({tag, ".done_T34"}, done, 1'b0);
        chk1({tag, ".wr_T34"}, hi_write | lo_write, 1'b0);
        chk1({tag, ".busy_T34"}, busy, 1'b0);
    endtask

    initial begin
        int bad;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = MULT; a = '0; b = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk1("reset.busy", busy, 1'b0);
        chk1("reset.done", done, 1'b0);
        chk1("reset.wr", hi_write | lo_write, 1'b0);
        chk("reset.hi", hi_out, 32'h0);
        chk("reset.lo", lo_out, 32'h0);

        run_op("mult_neg1x2",   MULT,  32'hFFFFFFFF, 32'h00000002, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("multu_max_x2",  MULTU, 32'hFFFFFFFF, 32'h00000002, 1'b1, 32'h00000001, 32'hFFFFFFFE);
        run_op("mult_minxmin",  MULT,  32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000);
        run_op("mult_m3x5",     MULT,  32'hFFFFFFFD, 32'h00000005, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("div_m7d2",      DIV,   32'hFFFFFFF9, 32'h00000002, DIV_ON, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu_by0",      DIVU,  32'h00000064, 32'h00000000, DIV_ON, 32'h00000064, 32'hFFFFFFFF);
        run_op("div_ovf",       DIV,   32'h80000000, 32'hFFFFFFFF, DIV_ON, 32'h00000000, 32'h80000000);
        run_op("divu_10d3",     DIVU,  32'h0000000A, 32'h00000003, DIV_ON, 32'h00000001, 32'h00000003);
        run_op("div_7dm2",      DIV,   32'h00000007, 32'hFFFFFFFE, DIV_ON, 32'h00000001, 32'hFFFFFFFD);

        // Restart attempt at T+10 must be ignored and not queued.
        start = 1'b1; op = MULTU; a = 32'd3; b = 32'd5;
        tick();
        bad = 0;
        for (int c = 1; c <= 32; c++) begin
            start = (c == 10);
            if (c == 10) begin a = 32'd7; b = 32'd7; end
            if (!busy) bad++;
            tick();
        end
        start = 1'b0;
        chk("restart.busy_run", 32'(bad), 32'd0);
        chk1("restart.busy_T33", busy, 1'b1);
        chk1("restart.done", done, 1'b1);
        chk("restart.hi", hi_out, 32'h0);
        chk("restart.lo", lo_out, 32'd15);
        exp_hi = 32'h0; exp_lo = 32'd15;
        tick();
        chk1("restart.busy_T34", busy, 1'b0);
        tick();
        chk1("restart.not_queued", busy, 1'b0);

        // Flush in IDLE blocks a simultaneous start.
        start = 1'b1; flush = 1'b1; op = MULT; a = 32'd2; b = 32'd2;
        tick();
        start = 1'b0; flush = 1'b0;
        chk1("flush_idle.busy", busy, 1'b0);

        // Flush mid-CALC: idle next cycle, never any strobe, hi/lo held.
        start = 1'b1; op = MULT; a = 32'd5; b = 32'd6;
        tick();
        start = 1'b0;
        repeat (11) tick();
        flush = 1'b1;
        chk1("flush_calc.busy_T12", busy, 1'b1);
        tick();
        flush = 1'b0;
        chk1("flush_calc.busy_T13", busy, 1'b0);
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            if (hi_write || lo_write || done || busy) bad++;
            tick();
        end
        chk("flush_calc.no_strobe", 32'(bad), 32'd0);
        chk("flush_calc.hi_held", hi_out, exp_hi);
        chk("flush_calc.lo_held", lo_out, exp_lo);

        // Reset at T+20: everything at reset values at T+21.
        start = 1'b1; op = MULT; a = 32'd9; b = 32'd9;
        tick();
        start = 1'b0;
        repeat (19) tick();
        rst = 1'b1;
        tick();
        chk1("rst_mid.busy", busy, 1'b0);
        chk1("rst_mid.done", done, 1'b0);
        chk1("rst_mid.wr", hi_write | lo_write, 1'b0);
        chk("rst_mid.hi", hi_out, 32'h0);
        chk("rst_mid.lo", lo_out, 32'h0);
        rst = 1'b0;
        exp_hi = '0; exp_lo = '0;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            if (hi_write || lo_write || done || busy) bad++;
            tick();
        end
        chk("rst_mid.no_strobe", 32'(bad), 32'd0);

        // Flush during DONE suppresses the strobes in that cycle.
        start = 1'b1; op = MULTU; a = 32'd2; b = 32'd3;
        tick();
        start = 1'b0;
        repeat (32) tick();
        flush = 1'b1;
        #1;
        chk1("flush_done.done", done, 1'b0);
        chk1("flush_done.wr", hi_write | lo_write, 1'b0);
        tick();
        flush = 1'b0;
        chk1("flush_done.busy", busy, 1'b0);

        run_op("multu_maxsq", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
